// File: rtl/sm_clk_pkg.sv
// Shared mode encodings and period-exponent helper for the CPU clock-enable generator.
package sm_clk_pkg;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_STEP   = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  // Period exponent: shift + div, clamped so 2^E - 1 still fits the down-counter.
  function automatic int unsigned clamp_exp(input int unsigned shift,
                                            input int unsigned div,
                                            input int unsigned cnt_w);
    int unsigned e;
    e = shift + div;
    if (e > cnt_w - 1) begin
      e = cnt_w - 1;
    end
    return e;
  endfunction

endpackage

// File: rtl/sm_btn_debouncer.sv
// Step-button conditioning: 2-flop synchronizer, stability counter, debounced level and
// a one-cycle strobe on each debounced rising edge.
module sm_btn_debouncer #(
  parameter int unsigned DEB_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async_i,
  output logic level_o,
  output logic rise_o
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Next state: count while the synchronized input disagrees with the level; any agreement
  // restarts the count, so only an input stable for 2^DEB_W cycles is accepted.
  always_comb begin
    sync1_d   = btn_async_i;
    sync2_d   = sync1_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    deb_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == '1) begin
        level_d   = sync2_q;
        rise_d    = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock-enable generator: stop, programmable power-of-two run, debounced single-step
// and full-speed bypass, plus a toggling indicator and a pulse counter for debug display.
module sm_clk_ctrl
  import sm_clk_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned SHIFT = 16,
  parameter int unsigned DEB_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] divide,
  input  logic             stepBtn,
  output logic             clkEn,
  output logic             clkOut,
  output logic [CNT_W-1:0] pulseCount,
  output logic             btnLevel
);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             clk_out_q, clk_out_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] reload;
  int unsigned      exp_w;
  logic             btn_rise;
  logic             entry;

  sm_btn_debouncer #(
    .DEB_W(DEB_W)
  ) u_btn_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_async_i(stepBtn),
    .level_o    (btnLevel),
    .rise_o     (btn_rise)
  );

  // Reload value P-1 = 2^E - 1 from the divide input as it stands right now.
  always_comb begin
    exp_w  = clamp_exp(SHIFT, 32'(divide), CNT_W);
    reload = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      reload[i] = (i < exp_w);
    end
  end

  // Next state: mode tracking, period counter, enable pulse, indicator and pulse count.
  always_comb begin
    mode_d      = mode_e'(mode);
    entry       = (mode_d != mode_q);
    cnt_d       = cnt_q;
    clk_en_d    = 1'b0;
    clk_out_d   = clk_out_q;
    pulse_cnt_d = pulse_cnt_q;
    unique case (mode_d)
      MODE_RUN: begin
        if (entry) begin
          cnt_d = reload;
        end else if (cnt_q == '0) begin
          clk_en_d = 1'b1;
          cnt_d    = reload;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // The strobe lasts one cycle, so edges seen outside STEP are simply lost.
      MODE_STEP:   clk_en_d = btn_rise;
      MODE_BYPASS: clk_en_d = 1'b1;
      MODE_STOP:   clk_en_d = 1'b0;
      default:     clk_en_d = 1'b0;
    endcase
    if (clk_en_d) begin
      clk_out_d   = ~clk_out_q;
      pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset forces STOP history so RUN is re-entered afresh on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_STOP;
      cnt_q       <= '0;
      clk_en_q    <= 1'b0;
      clk_out_q   <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      clk_out_q   <= clk_out_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign clkEn      = clk_en_q;
  assign clkOut     = clk_out_q;
  assign pulseCount = pulse_cnt_q;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Bench for sm_clk_ctrl: a wide-counter instance and a 3-bit-counter instance share inputs;
// a vector table walks RUN/STOP/BYPASS, hand sequences cover debounce, STEP and reset.
module tb_sm_clk_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] divide;
  logic       step_btn;

  logic       en, out, lvl;
  logic [7:0] pc;
  logic       enw, outw, lvlw;
  logic [2:0] pcw;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm_clk_ctrl #(
    .CNT_W(8),
    .DIV_W(4),
    .SHIFT(0),
    .DEB_W(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .divide    (divide),
    .stepBtn   (step_btn),
    .clkEn     (en),
    .clkOut    (out),
    .pulseCount(pc),
    .btnLevel  (lvl)
  );

  // Narrow counter: exercises the exponent clamp (E <= 2) and pulseCount wrap.
  sm_clk_ctrl #(
    .CNT_W(3),
    .DIV_W(4),
    .SHIFT(0),
    .DEB_W(2)
  ) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .divide    (divide),
    .stepBtn   (step_btn),
    .clkEn     (enw),
    .clkOut    (outw),
    .pulseCount(pcw),
    .btnLevel  (lvlw)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] divide;
    int         n;      // edges to apply with these inputs
    logic       en;
    logic       out;
    int         pc;
    logic       enw;
    logic       outw;
    int         pcw;
  } vec_t;

  vec_t vecs[14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_count(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (en) cnt++;
    end
  endtask

  initial begin
    int c, c0, n_en, first;
    logic any, l5, l6;

    // mode: 0 STOP, 1 RUN, 2 STEP, 3 BYPASS
    vecs[0]  = '{2'd1, 4'd2, 4, 1'b0, 1'b0, 0,  1'b0, 1'b0, 0};
    vecs[1]  = '{2'd1, 4'd2, 1, 1'b1, 1'b1, 1,  1'b1, 1'b1, 1};
    vecs[2]  = '{2'd1, 4'd2, 1, 1'b0, 1'b1, 1,  1'b0, 1'b1, 1};
    vecs[3]  = '{2'd1, 4'd2, 7, 1'b1, 1'b1, 3,  1'b1, 1'b1, 3};
    vecs[4]  = '{2'd1, 4'd2, 1, 1'b0, 1'b1, 3,  1'b0, 1'b1, 3};
    vecs[5]  = '{2'd1, 4'd3, 3, 1'b1, 1'b0, 4,  1'b1, 1'b0, 4};
    vecs[6]  = '{2'd1, 4'd3, 4, 1'b0, 1'b0, 4,  1'b1, 1'b1, 5};
    vecs[7]  = '{2'd1, 4'd3, 4, 1'b1, 1'b1, 5,  1'b1, 1'b0, 6};
    vecs[8]  = '{2'd0, 4'd3, 1, 1'b0, 1'b1, 5,  1'b0, 1'b0, 6};
    vecs[9]  = '{2'd3, 4'd3, 1, 1'b1, 1'b0, 6,  1'b1, 1'b1, 7};
    vecs[10] = '{2'd3, 4'd3, 1, 1'b1, 1'b1, 7,  1'b1, 1'b0, 0};
    vecs[11] = '{2'd3, 4'd3, 8, 1'b1, 1'b1, 15, 1'b1, 1'b0, 0};
    vecs[12] = '{2'd0, 4'd3, 1, 1'b0, 1'b1, 15, 1'b0, 1'b0, 0};
    vecs[13] = '{2'd1, 4'd2, 5, 1'b1, 1'b0, 16, 1'b1, 1'b1, 1};

    rst_n    = 1'b0;
    mode     = 2'd0;
    divide   = 4'd0;
    step_btn = 1'b0;
    tick();
    tick();
    chk("rst_clk_en", 32'(en), 0);
    chk("rst_clk_out", 32'(out), 0);
    chk("rst_pulse_count", 32'(pc), 0);
    chk("rst_btn_level", 32'(lvl), 0);

    // STOP after release: nothing may move.
    rst_n = 1'b1;
    any   = 1'b0;
    repeat (100) begin
      tick();
      if (en || out || pc != 0 || enw || outw || pcw != 0) any = 1'b1;
    end
    chk("stop_idle", 32'(any), 0);

    // RUN periods, divide change mid-period, clamp, STOP hold, BYPASS wrap, RUN re-entry.
    for (int r = 0; r < 14; r++) begin
      mode   = vecs[r].mode;
      divide = vecs[r].divide;
      repeat (vecs[r].n) tick();
      chk($sformatf("row%0d_en", r), 32'(en), 32'(vecs[r].en));
      chk($sformatf("row%0d_out", r), 32'(out), 32'(vecs[r].out));
      chk($sformatf("row%0d_pc", r), 32'(pc), 32'(vecs[r].pc));
      chk($sformatf("row%0d_enw", r), 32'(enw), 32'(vecs[r].enw));
      chk($sformatf("row%0d_outw", r), 32'(outw), 32'(vecs[r].outw));
      chk($sformatf("row%0d_pcw", r), 32'(pcw), 32'(vecs[r].pcw));
    end

    // STEP: one-cycle glitch must be rejected.
    mode   = 2'd2;
    divide = 4'd2;
    run_count(3, c);
    chk("step_entry_pulses", 32'(c), 0);
    step_btn = 1'b1;
    run_count(1, c0);
    step_btn = 1'b0;
    run_count(15, c);
    chk("glitch_pulses", 32'(c + c0), 0);
    chk("glitch_level", 32'(lvl), 0);

    // STEP: clean press held 20 cycles gives one pulse after edge 7.
    step_btn = 1'b1;
    n_en     = 0;
    first    = 0;
    l5       = 1'b0;
    l6       = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) l5 = lvl;
      if (i == 6) l6 = lvl;
      if (en) begin
        n_en++;
        if (first == 0) first = i;
      end
    end
    chk("press_pulses", 32'(n_en), 1);
    chk("press_edge", 32'(first), 7);
    chk("press_level_edge5", 32'(l5), 0);
    chk("press_level_edge6", 32'(l6), 1);
    chk("press_pc", 32'(pc), 17);
    chk("press_out", 32'(out), 1);
    step_btn = 1'b0;
    run_count(12, c);
    chk("release_pulses", 32'(c), 0);
    chk("release_level", 32'(lvl), 0);

    // Press during RUN, then switch to STEP: only RUN pulses, no latent step pulse.
    mode     = 2'd1;
    divide   = 4'd2;
    step_btn = 1'b1;
    run_count(13, c);
    chk("run_btn_pulses", 32'(c), 3);
    mode = 2'd2;
    run_count(10, c);
    chk("late_step_pulses", 32'(c), 0);
    chk("late_step_pc", 32'(pc), 20);
    chk("late_step_out", 32'(out), 0);
    step_btn = 1'b0;
    run_count(12, c);
    chk("late_release_pulses", 32'(c), 0);
    chk("late_release_level", 32'(lvl), 0);

    // Mode switches to STEP on the very edge the strobe is consumed: pulse issued.
    mode     = 2'd0;
    step_btn = 1'b1;
    run_count(6, c);
    chk("sim_step_pre_pulses", 32'(c), 0);
    mode = 2'd2;
    tick();
    chk("sim_step_en", 32'(en), 1);
    tick();
    chk("sim_step_single", 32'(en), 0);
    chk("sim_step_pc", 32'(pc), 21);
    step_btn = 1'b0;
    mode     = 2'd0;
    run_count(12, c);
    chk("sim_step_release_pulses", 32'(c), 0);

    // Mode leaves STEP on that same edge: no pulse.
    mode = 2'd2;
    run_count(2, c);
    step_btn = 1'b1;
    run_count(6, c0);
    mode = 2'd0;
    tick();
    chk("sim_stop_en", 32'(en), 0);
    run_count(5, c);
    chk("sim_stop_pulses", 32'(c + c0), 0);
    chk("sim_stop_pc", 32'(pc), 21);

    // Asynchronous reset mid-BYPASS with the button level high.
    mode = 2'd3;
    run_count(3, c);
    chk("pre_rst_en", 32'(en), 1);
    chk("pre_rst_level", 32'(lvl), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_en", 32'(en), 0);
    chk("rst_async_out", 32'(out), 0);
    chk("rst_async_pc", 32'(pc), 0);
    chk("rst_async_level", 32'(lvl), 0);
    chk("rst_async_pcw", 32'(pcw), 0);
    step_btn = 1'b0;
    mode     = 2'd1;
    divide   = 4'd2;
    @(posedge clk);
    #1;
    chk("rst_held_en", 32'(en), 0);
    rst_n = 1'b1;
    run_count(4, c);
    chk("rst_rerun_quiet", 32'(c), 0);
    tick();
    chk("rst_rerun_en", 32'(en), 1);
    chk("rst_rerun_pc", 32'(pc), 1);
    chk("rst_rerun_out", 32'(out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_clk_ctrl.md
# sm_clk_ctrl

Parametrised clock-control block for the CPU clock domain. It replaces the fixed-ratio derived clock with a single-cycle clock-enable pulse generator supporting four modes: stop, free-run with programmable power-of-two period, debounced single-step from a push button, and full-speed bypass. It sits between the board inputs (clock, reset, switches, step button) and the core, and also provides a visible square-wave indicator and a pulse counter for debug display.

## Interface
Parameters:
- CNT_W, 32, width of the period down-counter and of pulseCount.
- DIV_W, 4, width of the divide input.
- SHIFT, 16, base exponent added to divide.
- DEB_W, 16, debounce counter width; the button must be stable for 2^DEB_W cycles.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  2  synchronous mode select: 0 STOP, 1 RUN, 2 STEP, 3 BYPASS.
- divide  in  DIV_W  synchronous period exponent offset.
- stepBtn  in  1  raw asynchronous push button, active-high.
- clkEn  out  1  registered one-cycle enable pulse for the core.
- clkOut  out  1  registered indicator that toggles on every clkEn pulse.
- pulseCount  out  CNT_W  number of clkEn pulses issued; wraps modulo 2^CNT_W.
- btnLevel  out  1  debounced button level.

## Operation
- Period P = 2^E, where E = min(SHIFT + divide, CNT_W - 1).
- modeReg holds the mode sampled on the previous edge. A mode "entry" is any edge where mode != modeReg.
- STOP: clkEn <= 0. The down-counter holds its value.
- RUN:
  - On entry, the down-counter is loaded with P-1.
  - Otherwise the counter decrements each cycle.
  - When the counter is 0: clkEn <= 1 and the counter reloads with P-1 using the current divide.
  - A divide change takes effect only at the next reload or entry.
- STEP: clkEn <= 1 for exactly one cycle on each debounced rising edge of the button. Holding the button gives one pulse only.
- BYPASS: clkEn <= 1 on every edge while in this mode.
- Button rising edges detected while not in STEP are discarded. No latent pulse is issued after switching to STEP.
- Simultaneous mode change and button edge on the same clock edge: the mode input value at that edge decides the outcome.
- Debounce:
  - stepBtn passes through a 2-flop synchronizer (s2).
  - If s2 != btnLevel, debCnt increments; if they are equal, debCnt clears.
  - When debCnt == 2^DEB_W-1 and s2 still differs, btnLevel <= s2 and debCnt <= 0.
- Each clkEn pulse:
  - increments pulseCount (wraps to 0 after all-ones);
  - toggles clkOut.
- Reset values (asynchronous, immediate): clkEn 0, clkOut 0, pulseCount 0, btnLevel 0, synchronizer 0, debCnt 0, down-counter 0, modeReg STOP.
- Reset asserted mid-period or mid-debounce aborts the operation with no partial pulse. After release, RUN is entered afresh.

## Timing
- Debounce latency: with stepBtn changed and held stable before edge 1, btnLevel updates at edge 2^DEB_W+2.
- STEP latency: clkEn is high for the single cycle following edge 2^DEB_W+3.
- RUN latency: on entry at edge e, clkEn pulses follow edges e+P, e+2P, and so on.
- BYPASS latency: clkEn rises after the first entry edge. It falls one edge after leaving BYPASS.
- pulseCount and clkOut update on the same edge that raises clkEn.

## Structure
- Package sm_clk_pkg holds:
  - mode encodings MODE_STOP, MODE_RUN, MODE_STEP, MODE_BYPASS;
  - the clamp helper for E.
- Sub-module sm_btn_debouncer (parameter DEB_W) contains the synchronizer, debCnt and btnLevel. It outputs btnLevel and a one-cycle rise strobe.
- The top level contains modeReg, the down-counter, the clkEn/clkOut registers and pulseCount.

## Test plan
- Reset release with mode=STOP for 100 cycles -> clkEn, clkOut and pulseCount stay 0.
- SHIFT=0, divide=2, mode RUN from edge e -> clkEn pulses after e+4, e+8, e+12; pulseCount = 3; clkOut = 1.
- In RUN with divide changed 2->3 mid-period -> current period stays 4 cycles; following pulses are 8 cycles apart.
- DEB_W=2, mode STEP, 1-cycle glitch on stepBtn -> no pulse. Clean press held 20 cycles -> exactly one clkEn, after edge 7.
- Button press in RUN, then switch to STEP -> no extra pulse; pulseCount changes only with the RUN period.
- BYPASS for 10 cycles, CNT_W=3 -> pulseCount wraps 7->0 and clkEn stays high. rst_n asserted mid-run -> all outputs 0 immediately.
